// File: rtl/longop_pkg.sv
// Shared definitions for the long-op writeback scoreboard.
// Defines the architectural register constants, the per-unit FSM
// encoding and the result-FIFO entry layout.
// The entry layout, from LSB to MSB, is: data | rd | exc | unit.
package longop_pkg;

   localparam int REG_ZERO = 0;
   localparam int REG_EXC  = 30;

   // Per-unit tracking state; BUSY means an op is in flight.
   typedef enum logic {
      UNIT_IDLE = 1'b0,
      UNIT_BUSY = 1'b1
   } unit_state_e;

   // Bit position of the rd field within a FIFO entry.
   function automatic int ent_rd_lsb(input int data_w);
      return data_w;
   endfunction

   // Bit position of the exception flag within a FIFO entry.
   function automatic int ent_exc_bit(input int data_w, input int reg_w);
      return data_w + reg_w;
   endfunction

   // Bit position of the unit field within a FIFO entry.
   function automatic int ent_unit_lsb(input int data_w, input int reg_w);
      return data_w + reg_w + 1;
   endfunction

   // Total width of one FIFO entry.
   function automatic int ent_width(input int data_w, input int reg_w, input int unit_w);
      return data_w + reg_w + 1 + unit_w;
   endfunction

   // Number of set bits in an 8-bit vector; covers up to 8 units.
   function automatic int unsigned popcount8(input logic [7:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/longop_result_fifo.sv
// Result FIFO for completed long ops.
// Accepts up to NPUSH entries per cycle (stored in ascending push index
// order), pops at most one entry per cycle and exposes the head entry.
// A pushed entry becomes visible at the head on the following cycle.
// The caller guarantees there is never more data pushed than free slots.
module longop_result_fifo #(
   parameter int EW    = 40,
   parameter int DEPTH = 4,
   parameter int NPUSH = 2,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NPUSH-1:0]   push_valid,
   input  logic [NPUSH*EW-1:0] push_data,
   input  logic               pop,
   output logic [EW-1:0]      head,
   output logic [CW-1:0]      count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] slot [NPUSH];
   logic [CW-1:0] n_push;
   logic          pop_ok;

   // Assign consecutive slots to the valid pushes, lowest index first.
   always_comb begin
      n_push = '0;
      for (int i = 0; i < NPUSH; i++) begin
         slot[i] = PW'((int'(wr_ptr) + int'(n_push)) % DEPTH);
         if (push_valid[i]) begin
            n_push = n_push + CW'(1);
         end
      end
   end

   assign pop_ok = pop & (count != '0);
   assign head   = mem[rd_ptr];

   // Pointer and occupancy update; push and pop may coincide.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= PW'((int'(wr_ptr) + int'(n_push)) % DEPTH);
         if (pop_ok) begin
            rd_ptr <= PW'((int'(rd_ptr) + 1) % DEPTH);
         end
         count <= count + n_push - CW'(pop_ok);
      end
   end

   // Entry storage; contents are don't-care until counted as valid.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NPUSH; i++) begin
         if (push_valid[i]) begin
            mem[slot[i]] <= push_data[i*EW +: EW];
         end
      end
   end

endmodule

// File: rtl/longop_writeback_scoreboard.sv
// Long-op writeback scoreboard.
// Tracks the destination register of each in-flight multi-cycle op,
// raises a decode hazard for pending registers, queues completed results
// and drains them into the regfile port whenever the W stage leaves it free.
// Handshake: an issue is accepted on a rising edge where issue_valid and
// issue_ready are both high; issue_ready does not depend on issue_valid.
// unit_busy is the per-unit FSM state (1 = BUSY).
// Optional build macro LONGOP_EXC_R30_EN: entries flagged with an exception
// are redirected to $r30 carrying EXC_CODE_BASE + unit index.
module longop_writeback_scoreboard
   import longop_pkg::*;
#(
   parameter int NUM_UNITS     = 2,
   parameter int REG_W         = 5,
   parameter int DATA_W        = 32,
   parameter int QDEPTH        = 4,
   parameter int EXC_CODE_BASE = 4,
   localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
   localparam int CW = $clog2(QDEPTH) + 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        issue_valid,
   input  logic [UW-1:0]               issue_unit,
   input  logic [REG_W-1:0]            issue_rd,
   output logic                        issue_ready,
   input  logic [REG_W-1:0]            chk_rs,
   input  logic [REG_W-1:0]            chk_rt,
   input  logic [REG_W-1:0]            chk_rd,
   output logic                        hazard,
   input  logic [NUM_UNITS-1:0]        unit_done,
   input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
   input  logic [NUM_UNITS-1:0]        unit_exc,
   input  logic                        pipe_we,
   output logic                        wb_we,
   output logic [REG_W-1:0]            wb_reg,
   output logic [DATA_W-1:0]           wb_data,
   output logic [NUM_UNITS-1:0]        unit_busy,
   output logic [CW-1:0]               q_count,
   output logic                        spurious_done
);

   localparam int NUM_REGS = 2**REG_W;
   localparam int UEXT     = 1 << UW;
   localparam int EW       = ent_width(DATA_W, REG_W, UW);
   localparam int RD_LSB   = ent_rd_lsb(DATA_W);
   localparam int EXC_BIT  = ent_exc_bit(DATA_W, REG_W);
   localparam int UNIT_LSB = ent_unit_lsb(DATA_W, REG_W);

   unit_state_e             state   [NUM_UNITS];
   logic [REG_W-1:0]        unit_rd [NUM_UNITS];
   logic [NUM_REGS-1:0]     pending;
   logic                    spurious_q;
   logic [UEXT-1:0]         busy_ext;
   logic                    unit_in_range;
   logic                    reserve_ok;
   logic                    issue_accept;
   logic [NUM_UNITS-1:0]    push_valid;
   logic [NUM_UNITS-1:0]    done_idle;
   logic [NUM_UNITS*EW-1:0] push_data;
   logic [EW-1:0]           head;
   logic [REG_W-1:0]        head_rd;
   logic                    q_nonempty;

   // Expose each unit's FSM state as a busy bit.
   always_comb begin
      unit_busy = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         unit_busy[i] = (state[i] == UNIT_BUSY);
      end
   end

   // Accept only into an idle unit, a non-pending rd, and with a FIFO slot
   // still unreserved by the busy units so no completion can overflow.
   always_comb begin
      busy_ext      = UEXT'(unit_busy);
      unit_in_range = (int'(issue_unit) < NUM_UNITS);
      reserve_ok    = (int'(q_count) + int'(popcount8(8'(unit_busy)))) < QDEPTH;
      issue_ready   = reset & unit_in_range & ~busy_ext[issue_unit]
                      & ~pending[issue_rd] & reserve_ok;
   end

   assign issue_accept = issue_valid & issue_ready;

   // Build FIFO entries for completing units; done on an idle unit is dropped.
   always_comb begin
      push_valid = '0;
      done_idle  = '0;
      push_data  = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         push_valid[i] = unit_done[i] & unit_busy[i];
         done_idle[i]  = unit_done[i] & ~unit_busy[i];
         push_data[i*EW +: EW] = {UW'(i), unit_exc[i], unit_rd[i],
                                  unit_result[i*DATA_W +: DATA_W]};
      end
   end

   longop_result_fifo #(
      .EW    (EW),
      .DEPTH (QDEPTH),
      .NPUSH (NUM_UNITS)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_valid (push_valid),
      .push_data  (push_data),
      .pop        (wb_we),
      .head       (head),
      .count      (q_count)
   );

   assign head_rd    = head[RD_LSB +: REG_W];
   assign q_nonempty = (q_count != '0);
   assign wb_we      = q_nonempty & ~pipe_we;

`ifdef LONGOP_EXC_R30_EN
   logic          head_exc;
   logic [UW-1:0] head_unit;
   assign head_exc  = head[EXC_BIT];
   assign head_unit = head[UNIT_LSB +: UW];

   // Present the head entry, redirecting exception entries to $r30.
   always_comb begin
      wb_reg  = '0;
      wb_data = '0;
      if (q_nonempty) begin
         if (head_exc) begin
            wb_reg  = REG_W'(REG_EXC);
            wb_data = DATA_W'(EXC_CODE_BASE) + DATA_W'(head_unit);
         end else begin
            wb_reg  = head_rd;
            wb_data = head[DATA_W-1:0];
         end
      end
   end
`else
   logic unused_head_meta;
   assign unused_head_meta = ^{head[EXC_BIT], head[UNIT_LSB +: UW]};

   // Present the head entry; the exception flag plays no part here.
   always_comb begin
      wb_reg  = '0;
      wb_data = '0;
      if (q_nonempty) begin
         wb_reg  = head_rd;
         wb_data = head[DATA_W-1:0];
      end
   end
`endif

   // Pending registers gate decode; register 0 is never pending.
   always_comb begin
      hazard = ((chk_rs != REG_W'(REG_ZERO)) & pending[chk_rs])
             | ((chk_rt != REG_W'(REG_ZERO)) & pending[chk_rt])
             | ((chk_rd != REG_W'(REG_ZERO)) & pending[chk_rd]);
   end

   assign spurious_done = spurious_q;

   // Per-unit IDLE/BUSY FSM, pending bitmap and sticky spurious flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending    <= '0;
         spurious_q <= 1'b0;
         for (int i = 0; i < NUM_UNITS; i++) begin
            state[i]   <= UNIT_IDLE;
            unit_rd[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (push_valid[i]) begin
               state[i] <= UNIT_IDLE;
            end else if (issue_accept && (int'(issue_unit) == i)) begin
               state[i]   <= UNIT_BUSY;
               unit_rd[i] <= issue_rd;
            end
         end
         if (|done_idle) begin
            spurious_q <= 1'b1;
         end
         // Clear on pop before set on issue; they never target the same rd.
         if (wb_we) begin
            pending[head_rd] <= 1'b0;
         end
         if (issue_accept && (issue_rd != REG_W'(REG_ZERO))) begin
            pending[issue_rd] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_longop_writeback_scoreboard.sv
// Directed bench for longop_writeback_scoreboard (default parameters).
module tb_longop_writeback_scoreboard;

   localparam int NUM_UNITS = 2;
   localparam int REG_W     = 5;
   localparam int DATA_W    = 32;
   localparam int QDEPTH    = 4;
   localparam int CW        = $clog2(QDEPTH) + 1;

   logic                        clock = 1'b0;
   logic                        reset = 1'b0;
   logic                        issue_valid;
   logic [0:0]                  issue_unit;
   logic [REG_W-1:0]            issue_rd;
   logic                        issue_ready;
   logic [REG_W-1:0]            chk_rs, chk_rt, chk_rd;
   logic                        hazard;
   logic [NUM_UNITS-1:0]        unit_done;
   logic [NUM_UNITS*DATA_W-1:0] unit_result;
   logic [NUM_UNITS-1:0]        unit_exc;
   logic                        pipe_we;
   logic                        wb_we;
   logic [REG_W-1:0]            wb_reg;
   logic [DATA_W-1:0]           wb_data;
   logic [NUM_UNITS-1:0]        unit_busy;
   logic [CW-1:0]               q_count;
   logic                        spurious_done;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [REG_W+DATA_W-1:0] exp_q [$];

   longop_writeback_scoreboard dut (
      .clock         (clock),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_unit    (issue_unit),
      .issue_rd      (issue_rd),
      .issue_ready   (issue_ready),
      .chk_rs        (chk_rs),
      .chk_rt        (chk_rt),
      .chk_rd        (chk_rd),
      .hazard        (hazard),
      .unit_done     (unit_done),
      .unit_result   (unit_result),
      .unit_exc      (unit_exc),
      .pipe_we       (pipe_we),
      .wb_we         (wb_we),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .unit_busy     (unit_busy),
      .q_count       (q_count),
      .spurious_done (spurious_done)
   );

   // Clock
   always #5 clock = ~clock;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Issue one op; it must be accepted on the next edge.
   task automatic issue(input int u, input int rd);
      issue_valid = 1'b1;
      issue_unit  = 1'(u);
      issue_rd    = REG_W'(rd);
      settle();
      check($sformatf("issue_ready_u%0d_r%0d", u, rd), 64'(issue_ready), 64'd1);
      tick();
      issue_valid = 1'b0;
   endtask

   // Release the port and compare each writeback against exp_q in order.
   task automatic drain(input int max_cycles, output int cycles);
      logic [REG_W+DATA_W-1:0] e;
      pipe_we = 1'b0;
      cycles  = 0;
      while (exp_q.size() != 0 && cycles < max_cycles) begin
         settle();
         if (wb_we) begin
            e = exp_q.pop_front();
            check("drain_wb_reg", 64'(wb_reg), 64'(e[REG_W+DATA_W-1:DATA_W]));
            check("drain_wb_data", 64'(wb_data), 64'(e[DATA_W-1:0]));
         end
         tick();
         cycles++;
      end
      check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
      check("drain_q_count", 64'(q_count), 64'd0);
   endtask

   initial begin
      int cyc;
      issue_valid = 1'b0;
      issue_unit  = '0;
      issue_rd    = '0;
      chk_rs      = '0;
      chk_rt      = '0;
      chk_rd      = '0;
      unit_done   = '0;
      unit_result = '0;
      unit_exc    = '0;
      pipe_we     = 1'b0;

      // Reset state
      #2;
      check("rst_wb_we", 64'(wb_we), 64'd0);
      check("rst_q_count", 64'(q_count), 64'd0);
      check("rst_unit_busy", 64'(unit_busy), 64'd0);
      check("rst_spurious", 64'(spurious_done), 64'd0);
      check("rst_hazard", 64'(hazard), 64'd0);
      check("rst_issue_ready", 64'(issue_ready), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      tick();

      // Single op: unit0 rd=5, done 3 cycles after issue
      chk_rs      = 5'd5;
      issue_valid = 1'b1;
      issue_unit  = 1'b0;
      issue_rd    = 5'd5;
      settle();
      check("t1_ready", 64'(issue_ready), 64'd1);
      check("t1_hazard_pre", 64'(hazard), 64'd0);
      tick();
      issue_valid = 1'b0;
      check("t1_hazard_issue1", 64'(hazard), 64'd1);
      check("t1_busy", 64'(unit_busy), 64'd1);
      tick();
      tick();
      check("t1_hazard_wait", 64'(hazard), 64'd1);
      unit_done   = 2'b01;
      unit_result = {32'h0, 32'h0000_1234};
      tick();
      unit_done = '0;
      check("t1_q_count", 64'(q_count), 64'd1);
      check("t1_wb_we", 64'(wb_we), 64'd1);
      check("t1_wb_reg", 64'(wb_reg), 64'd5);
      check("t1_wb_data", 64'(wb_data), 64'h1234);
      check("t1_hazard_queued", 64'(hazard), 64'd1);
      check("t1_busy_done", 64'(unit_busy), 64'd0);
      tick();
      check("t1_hazard_popped", 64'(hazard), 64'd0);
      check("t1_wb_we_after", 64'(wb_we), 64'd0);
      check("t1_q_after", 64'(q_count), 64'd0);

      // Two units complete together while W owns the port
      chk_rs = '0;
      issue(0, 3);
      issue(1, 7);
      check("t2_busy", 64'(unit_busy), 64'd3);
      pipe_we     = 1'b1;
      unit_done   = 2'b11;
      unit_result = {32'hBBBB_0007, 32'hAAAA_0003};
      tick();
      unit_done = '0;
      check("t2_q_count", 64'(q_count), 64'd2);
      check("t2_wb_we_blocked", 64'(wb_we), 64'd0);
      tick();
      check("t2_q_count_hold", 64'(q_count), 64'd2);
      exp_q.push_back({5'd3, 32'hAAAA_0003});
      exp_q.push_back({5'd7, 32'hBBBB_0007});
      drain(6, cyc);
      check("t2_drain_cycles", 64'(cyc), 64'd2);

      // Issue gating and hazard ports
      issue(0, 5);
      issue_unit = 1'b1;
      issue_rd   = 5'd5;
      settle();
      check("t3_ready_pending", 64'(issue_ready), 64'd0);
      issue_unit = 1'b0;
      issue_rd   = 5'd9;
      settle();
      check("t3_ready_busy", 64'(issue_ready), 64'd0);
      issue_unit = 1'b1;
      settle();
      check("t3_ready_ok", 64'(issue_ready), 64'd1);
      chk_rt = 5'd5;
      settle();
      check("t3_hazard_rt", 64'(hazard), 64'd1);
      chk_rt = '0;
      chk_rd = 5'd5;
      settle();
      check("t3_hazard_rd", 64'(hazard), 64'd1);
      chk_rd = 5'd6;
      settle();
      check("t3_hazard_none", 64'(hazard), 64'd0);
      chk_rd = '0;

      // Fill the FIFO to 3 and reserve the last slot for a busy unit
      pipe_we     = 1'b1;
      unit_done   = 2'b01;
      unit_result = {32'h0, 32'h0000_0055};
      tick();
      unit_done = '0;
      exp_q.push_back({5'd5, 32'h0000_0055});
      issue(0, 6);
      issue(1, 8);
      unit_done   = 2'b11;
      unit_result = {32'h0000_0088, 32'h0000_0066};
      tick();
      unit_done = '0;
      exp_q.push_back({5'd6, 32'h0000_0066});
      exp_q.push_back({5'd8, 32'h0000_0088});
      check("t3_q_count3", 64'(q_count), 64'd3);
      issue(1, 11);
      issue_unit = 1'b0;
      issue_rd   = 5'd12;
      settle();
      check("t3_ready_reserve", 64'(issue_ready), 64'd0);
      check("t3_busy_u1", 64'(unit_busy), 64'd2);
      unit_done   = 2'b10;
      unit_result = {32'h0000_0011, 32'h0};
      tick();
      unit_done = '0;
      exp_q.push_back({5'd11, 32'h0000_0011});
      check("t3_q_count_full", 64'(q_count), 64'd4);
      drain(10, cyc);
      check("t3_drain_cycles", 64'(cyc), 64'd4);

      // Done on an idle unit
      unit_done = 2'b10;
      tick();
      unit_done = '0;
      check("t4_spurious", 64'(spurious_done), 64'd1);
      check("t4_q_count", 64'(q_count), 64'd0);
      check("t4_wb_we", 64'(wb_we), 64'd0);

      // Exception-flagged completion from unit1, rd=4
      issue(1, 4);
      chk_rs      = 5'd4;
      unit_done   = 2'b10;
      unit_exc    = 2'b10;
      unit_result = {32'hDEAD_0004, 32'h0};
      tick();
      unit_done = '0;
      unit_exc  = '0;
      check("t5_wb_we", 64'(wb_we), 64'd1);
`ifdef LONGOP_EXC_R30_EN
      check("t5_wb_reg_exc", 64'(wb_reg), 64'd30);
      check("t5_wb_data_exc", 64'(wb_data), 64'd5);
`else
      check("t5_wb_reg", 64'(wb_reg), 64'd4);
      check("t5_wb_data", 64'(wb_data), 64'hDEAD_0004);
`endif
      tick();
      check("t5_pending_clear", 64'(hazard), 64'd0);
      chk_rs = 5'd30;
      settle();
      check("t5_r30_not_pending", 64'(hazard), 64'd0);

      // Reset in the middle of an op with one entry queued
      issue(0, 9);
      issue(1, 12);
      chk_rs      = 5'd9;
      pipe_we     = 1'b1;
      unit_done   = 2'b10;
      unit_result = {32'h0000_0C0C, 32'h0};
      tick();
      unit_done = '0;
      check("t6_pre_q_count", 64'(q_count), 64'd1);
      check("t6_pre_busy", 64'(unit_busy), 64'd1);
      check("t6_pre_hazard", 64'(hazard), 64'd1);
      pipe_we    = 1'b0;
      issue_unit = 1'b0;
      issue_rd   = 5'd1;
      settle();
      reset = 1'b0;
      settle();
      check("t6_rst_busy", 64'(unit_busy), 64'd0);
      check("t6_rst_q_count", 64'(q_count), 64'd0);
      check("t6_rst_wb_we", 64'(wb_we), 64'd0);
      check("t6_rst_wb_reg", 64'(wb_reg), 64'd0);
      check("t6_rst_wb_data", 64'(wb_data), 64'd0);
      check("t6_rst_hazard", 64'(hazard), 64'd0);
      check("t6_rst_spurious", 64'(spurious_done), 64'd0);
      check("t6_rst_issue_ready", 64'(issue_ready), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      settle();
      check("t6_post_hazard", 64'(hazard), 64'd0);
      check("t6_post_ready", 64'(issue_ready), 64'd1);
      unit_done = 2'b01;
      tick();
      unit_done = '0;
      check("t6_stale_spurious", 64'(spurious_done), 64'd1);
      check("t6_stale_q_count", 64'(q_count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
